alu_cmd_sequencer: RTL and testbench

Command-side front end for the 16-bit combinational ALU: accepts operation requests over a valid/ready handshake, buffers them in a small FIFO, drives the ALU operand/select inputs from registers, captures the ALU result and returns it over a second valid/ready handshake. It sits between any command master (test sequencer, microcontroller datapath) and the ALU. Results return strictly in command order.

---
 rtl/alu_pkg.sv | 23 ++
 rtl/alu_cmd_fifo.sv | 62 ++++++
 rtl/alu_cmd_sequencer.sv | 157 +++++++++++++++
 tb/tb_alu_cmd_sequencer.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared types for the ALU command sequencer: opcode encoding and sequencer FSM states.
package alu_pkg;

   localparam int ALU_SEL_W = 3;

   typedef enum logic [ALU_SEL_W-1:0] {
      ALU_ADD = 3'b000,
      ALU_SUB = 3'b001,
      ALU_AND = 3'b010,
      ALU_OR  = 3'b011,
      ALU_XOR = 3'b100,
      ALU_NOT = 3'b101,
      ALU_SHL = 3'b110,
      ALU_SHR = 3'b111
   } alu_sel_e;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      HOLD  = 2'd2
   } seq_state_e;

endpackage

// File: rtl/alu_cmd_fifo.sv
// Command FIFO holding {sel, a, b} entries; DEPTH must be a power of two (>= 2),
// with one extra wrap bit on each pointer to tell full from empty.
module alu_cmd_fifo
   import alu_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int DEPTH = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 push,
   input  logic [ALU_SEL_W-1:0] push_sel,
   input  logic [WIDTH-1:0]     push_a,
   input  logic [WIDTH-1:0]     push_b,
   input  logic                 pop,
   output logic [ALU_SEL_W-1:0] head_sel,
   output logic [WIDTH-1:0]     head_a,
   output logic [WIDTH-1:0]     head_b,
   output logic                 full,
   output logic                 empty
);

   localparam int AW      = $clog2(DEPTH);
   localparam int ENTRY_W = ALU_SEL_W + 2 * WIDTH;

   logic [ENTRY_W-1:0] mem_q [DEPTH];
   logic [AW:0]        wr_ptr_q, wr_ptr_d;
   logic [AW:0]        rd_ptr_q, rd_ptr_d;
   logic               do_push, do_pop;

   assign empty   = (wr_ptr_q == rd_ptr_q);
   assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                    (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;

   always_comb begin
      wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, do_push};
      rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, do_pop};
   end

   // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   // NOTE: storage is deliberately not reset; the pointers alone define which entries are live.
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem_q[wr_ptr_q[AW-1:0]] <= {push_sel, push_a, push_b};
      end
   end

   assign {head_sel, head_a, head_b} = mem_q[rd_ptr_q[AW-1:0]];

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Front end for the combinational ALU: queues commands, issues them one at a time and
// returns results in order. Define ALU_SEQ_FLAGS_EN to add res_zero/res_neg outputs.
module alu_cmd_sequencer
   import alu_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int DEPTH = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 cmd_valid,
   output logic                 cmd_ready,
   input  logic [ALU_SEL_W-1:0] cmd_sel,
   input  logic [WIDTH-1:0]     cmd_a,
   input  logic [WIDTH-1:0]     cmd_b,
   output logic [WIDTH-1:0]     alu_a,
   output logic [WIDTH-1:0]     alu_b,
   output logic [ALU_SEL_W-1:0] alu_sel,
   input  logic [WIDTH-1:0]     alu_out,
   output logic                 res_valid,
   input  logic                 res_ready,
   output logic [WIDTH-1:0]     res_data,
   output logic [ALU_SEL_W-1:0] res_sel,
   output logic                 busy
`ifdef ALU_SEQ_FLAGS_EN
   ,
   output logic                 res_zero,
   output logic                 res_neg
`endif
);

   seq_state_e           state_q, state_d;
   logic [WIDTH-1:0]     alu_a_q, alu_a_d;
   logic [WIDTH-1:0]     alu_b_q, alu_b_d;
   alu_sel_e             alu_sel_q, alu_sel_d;
   logic                 res_valid_q, res_valid_d;
   logic [WIDTH-1:0]     res_data_q, res_data_d;
   alu_sel_e             res_sel_q, res_sel_d;
`ifdef ALU_SEQ_FLAGS_EN
   logic                 res_zero_q, res_zero_d;
   logic                 res_neg_q, res_neg_d;
`endif

   logic                 fifo_full, fifo_empty, fifo_pop, load;
   logic [ALU_SEL_W-1:0] head_sel;
   logic [WIDTH-1:0]     head_a, head_b;

   alu_cmd_fifo #(
      .WIDTH(WIDTH),
      .DEPTH(DEPTH)
   ) u_fifo (
      .clk      (clk),
      .rst      (rst),
      .push     (cmd_valid),
      .push_sel (cmd_sel),
      .push_a   (cmd_a),
      .push_b   (cmd_b),
      .pop      (fifo_pop),
      .head_sel (head_sel),
      .head_a   (head_a),
      .head_b   (head_b),
      .full     (fifo_full),
      .empty    (fifo_empty)
   );

   // NOTE: every comb output gets a default first so no path can infer a latch.
   always_comb begin
      state_d     = state_q;
      load        = 1'b0;
      alu_a_d     = alu_a_q;
      alu_b_d     = alu_b_q;
      alu_sel_d   = alu_sel_q;
      res_valid_d = res_valid_q;
      res_data_d  = res_data_q;
      res_sel_d   = res_sel_q;
`ifdef ALU_SEQ_FLAGS_EN
      res_zero_d  = res_zero_q;
      res_neg_d   = res_neg_q;
`endif

      case (state_q)
         IDLE: begin
            load = !fifo_empty;
         end
         ISSUE: begin
            res_data_d  = alu_out;
            res_sel_d   = alu_sel_q;
            res_valid_d = 1'b1;
`ifdef ALU_SEQ_FLAGS_EN
            res_zero_d  = (alu_out == '0);
            res_neg_d   = alu_out[WIDTH-1];
`endif
            state_d     = HOLD;
         end
         HOLD: begin
            if (res_valid_q && res_ready) begin
               res_valid_d = 1'b0;
               load        = !fifo_empty;
               state_d     = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      // Loading the next command always hands the ALU one cycle before capture.
      if (load) begin
         alu_a_d   = head_a;
         alu_b_d   = head_b;
         alu_sel_d = alu_sel_e'(head_sel);
         state_d   = ISSUE;
      end
   end

   assign fifo_pop = load;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         alu_a_q     <= '0;
         alu_b_q     <= '0;
         alu_sel_q   <= ALU_ADD;
         res_valid_q <= 1'b0;
         res_data_q  <= '0;
         res_sel_q   <= ALU_ADD;
`ifdef ALU_SEQ_FLAGS_EN
         res_zero_q  <= 1'b0;
         res_neg_q   <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         alu_a_q     <= alu_a_d;
         alu_b_q     <= alu_b_d;
         alu_sel_q   <= alu_sel_d;
         res_valid_q <= res_valid_d;
         res_data_q  <= res_data_d;
         res_sel_q   <= res_sel_d;
`ifdef ALU_SEQ_FLAGS_EN
         res_zero_q  <= res_zero_d;
         res_neg_q   <= res_neg_d;
`endif
      end
   end

   assign cmd_ready = !fifo_full;
   assign busy      = !fifo_empty || (state_q != IDLE);
   assign alu_a     = alu_a_q;
   assign alu_b     = alu_b_q;
   assign alu_sel   = alu_sel_q;
   assign res_valid = res_valid_q;
   assign res_data  = res_data_q;
   assign res_sel   = res_sel_q;
`ifdef ALU_SEQ_FLAGS_EN
   assign res_zero  = res_zero_q;
   assign res_neg   = res_neg_q;
`endif

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Bench for alu_cmd_sequencer: directed commands, an in-order result scoreboard and
// literal spot checks. Flag checks are compiled in when ALU_SEQ_FLAGS_EN is defined.
module tb_alu_cmd_sequencer;

   localparam int W = 16;

   logic          clk = 1'b0;
   logic          rst;
   logic          cmd_valid, cmd_ready;
   logic [2:0]    cmd_sel;
   logic [W-1:0]  cmd_a, cmd_b;
   logic [W-1:0]  alu_a, alu_b, alu_out;
   logic [2:0]    alu_sel;
   logic          res_valid, res_ready;
   logic [W-1:0]  res_data;
   logic [2:0]    res_sel;
   logic          busy;
`ifdef ALU_SEQ_FLAGS_EN
   logic          res_zero, res_neg;
`endif

   int n_checks = 0;
   int n_fail   = 0;
   int n_consumed = 0;

   typedef struct {
      logic [2:0]   sel;
      logic [W-1:0] data;
   } exp_t;
   exp_t sb[$];

   alu_cmd_sequencer #(.WIDTH(W), .DEPTH(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_sel   (cmd_sel),
      .cmd_a     (cmd_a),
      .cmd_b     (cmd_b),
      .alu_a     (alu_a),
      .alu_b     (alu_b),
      .alu_sel   (alu_sel),
      .alu_out   (alu_out),
      .res_valid (res_valid),
      .res_ready (res_ready),
      .res_data  (res_data),
      .res_sel   (res_sel),
      .busy      (busy)
`ifdef ALU_SEQ_FLAGS_EN
      ,
      .res_zero  (res_zero),
      .res_neg   (res_neg)
`endif
   );

   always #5 clk = ~clk;

   function automatic logic [W-1:0] alu_fn(input logic [2:0] sel,
                                           input logic [W-1:0] a,
                                           input logic [W-1:0] b);
      case (sel)
         3'd0:    return a + b;
         3'd1:    return a - b;
         3'd2:    return a & b;
         3'd3:    return a | b;
         3'd4:    return a ^ b;
         3'd5:    return ~a;
         3'd6:    return a << 1;
         default: return a >> 1;
      endcase
   endfunction

   // The ALU itself lives outside the sequencer.
   always_comb alu_out = alu_fn(alu_sel, alu_a, alu_b);

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Scoreboard: expected results in command order, checked every falling edge.
   logic         hold_prev = 1'b0;
   logic [W-1:0] prev_data;
   logic [2:0]   prev_sel;

   always @(negedge clk) begin
      if (rst) begin
         sb.delete();
         hold_prev = 1'b0;
      end else begin
         check("busy", busy, (sb.size() != 0));
         if (hold_prev) begin
            check("hold_valid", res_valid, 1'b1);
            check("hold_data", res_data, prev_data);
            check("hold_sel", res_sel, prev_sel);
         end
         if (res_valid) begin
            if (sb.size() == 0) begin
               check("unexpected_result", res_valid, 1'b0);
            end else begin
               check("sb_data", res_data, sb[0].data);
               check("sb_sel", res_sel, sb[0].sel);
`ifdef ALU_SEQ_FLAGS_EN
               check("sb_zero", res_zero, (sb[0].data == '0));
               check("sb_neg", res_neg, sb[0].data[W-1]);
`endif
               if (res_ready) begin
                  void'(sb.pop_front());
                  n_consumed++;
               end
            end
         end
         if (cmd_valid && cmd_ready) begin
            sb.push_back('{sel: cmd_sel, data: alu_fn(cmd_sel, cmd_a, cmd_b)});
         end
         hold_prev = res_valid && !res_ready;
         prev_data = res_data;
         prev_sel  = res_sel;
      end
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [2:0] sel, input logic [W-1:0] a, input logic [W-1:0] b);
      int n = 0;
      cmd_sel   = sel;
      cmd_a     = a;
      cmd_b     = b;
      cmd_valid = 1'b1;
      while (!cmd_ready && n < 50) begin
         tick();
         n++;
      end
      if (!cmd_ready) check("send_timeout", cmd_ready, 1'b1);
      tick();
      cmd_valid = 1'b0;
   endtask

   task automatic expect_result(input string name, input logic [W-1:0] data, input logic [2:0] sel);
      int n = 0;
      while (!res_valid && n < 20) begin
         tick();
         n++;
      end
      check({name, "_valid"}, res_valid, 1'b1);
      check({name, "_data"}, res_data, data);
      check({name, "_sel"}, res_sel, sel);
   endtask

   task automatic wait_idle;
      int n = 0;
      while (busy && n < 100) begin
         tick();
         n++;
      end
      check("idle_timeout", busy, 1'b0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   logic [2:0]   bp_sel [6];
   logic [W-1:0] bp_a   [6];
   logic [W-1:0] bp_b   [6];

   initial begin
      int accepted, cyc, consumed_base, seen;
      logic r;

      bp_sel = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5};
      bp_a   = '{16'h1111, 16'h5000, 16'hF0F0, 16'hF000, 16'hAAAA, 16'h1234};
      bp_b   = '{16'h2222, 16'h1000, 16'h3C3C, 16'h000F, 16'hFFFF, 16'h0000};

      rst       = 1'b1;
      cmd_valid = 1'b0;
      cmd_sel   = '0;
      cmd_a     = '0;
      cmd_b     = '0;
      res_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      tick();

      check("rst_cmd_ready", cmd_ready, 1'b1);
      check("rst_alu_a", alu_a, 16'h0000);
      check("rst_alu_b", alu_b, 16'h0000);
      check("rst_alu_sel", alu_sel, 3'b000);
      check("rst_res_valid", res_valid, 1'b0);
      check("rst_res_data", res_data, 16'h0000);
      check("rst_res_sel", res_sel, 3'b000);
      check("rst_busy", busy, 1'b0);
`ifdef ALU_SEQ_FLAGS_EN
      check("rst_res_zero", res_zero, 1'b0);
      check("rst_res_neg", res_neg, 1'b0);
`endif

      // ADD latency: accepted at edge k, result visible after k+2.
      res_ready = 1'b1;
      send(3'd0, 16'h0003, 16'h0004);
      check("add_k_valid", res_valid, 1'b0);
      tick();
      check("add_k1_valid", res_valid, 1'b0);
      check("add_k1_alu_a", alu_a, 16'h0003);
      check("add_k1_alu_b", alu_b, 16'h0004);
      check("add_k1_alu_sel", alu_sel, 3'd0);
      tick();
      check("add_k2_valid", res_valid, 1'b1);
      check("add_k2_data", res_data, 16'h0007);
      check("add_k2_sel", res_sel, 3'd0);
      tick();

      send(3'd1, 16'h0000, 16'h0001);
      expect_result("sub", 16'hFFFF, 3'd1);
`ifdef ALU_SEQ_FLAGS_EN
      check("sub_neg", res_neg, 1'b1);
      check("sub_zero", res_zero, 1'b0);
`endif
      tick();

      send(3'd4, 16'h00FF, 16'h00FF);
      expect_result("xor", 16'h0000, 3'd4);
`ifdef ALU_SEQ_FLAGS_EN
      check("xor_zero", res_zero, 1'b1);
      check("xor_neg", res_neg, 1'b0);
`endif
      tick();

      send(3'd6, 16'h8001, 16'h0000);
      expect_result("shl", 16'h0002, 3'd6);
      tick();
      send(3'd7, 16'h8001, 16'h0000);
      expect_result("shr", 16'h4000, 3'd7);
      tick();
      send(3'd5, 16'h00F0, 16'h0000);
      expect_result("not", 16'hFF0F, 3'd5);
      tick();
      repeat (3) tick();
      check("keep_alu_a", alu_a, 16'h00F0);
      check("keep_alu_sel", alu_sel, 3'd5);

      // Six back-to-back commands with the consumer stalled: only five fit.
      res_ready     = 1'b0;
      consumed_base = n_consumed;
      accepted      = 0;
      for (cyc = 0; cyc < 8 && accepted < 6; cyc++) begin
         cmd_sel   = bp_sel[accepted];
         cmd_a     = bp_a[accepted];
         cmd_b     = bp_b[accepted];
         cmd_valid = 1'b1;
         r         = cmd_ready;
         tick();
         if (r) accepted++;
      end
      check("bp_accepted", accepted, 5);
      check("bp_cmd_ready", cmd_ready, 1'b0);
      repeat (10) tick();
      check("bp_hold_data", res_data, 16'h3333);
      check("bp_hold_sel", res_sel, 3'd0);
      check("bp_hold_valid", res_valid, 1'b1);
      check("bp_still_full", cmd_ready, 1'b0);

      res_ready = 1'b1;
      for (cyc = 0; cyc < 20 && accepted < 6; cyc++) begin
         r = cmd_ready;
         tick();
         if (r) accepted++;
      end
      cmd_valid = 1'b0;
      check("bp_sixth_accepted", accepted, 6);
      check("bp_sixth_after_first", n_consumed - consumed_base, 1);
      wait_idle();
      check("bp_consumed", n_consumed - consumed_base, 6);

      // Reset with work in flight discards everything.
      res_ready = 1'b0;
      send(3'd0, 16'h0001, 16'h0001);
      send(3'd1, 16'h0009, 16'h0002);
      send(3'd2, 16'h00FF, 16'h000F);
      send(3'd3, 16'h0100, 16'h0001);
      repeat (3) tick();
      check("pre_rst_valid", res_valid, 1'b1);
      check("pre_rst_busy", busy, 1'b1);
      #2 rst = 1'b1;
      #1;
      check("mid_rst_valid", res_valid, 1'b0);
      check("mid_rst_busy", busy, 1'b0);
      check("mid_rst_cmd_ready", cmd_ready, 1'b1);
      check("mid_rst_alu_a", alu_a, 16'h0000);
      check("mid_rst_alu_b", alu_b, 16'h0000);
      check("mid_rst_alu_sel", alu_sel, 3'd0);
      check("mid_rst_res_data", res_data, 16'h0000);
      @(posedge clk);
      #1 rst = 1'b0;
      res_ready = 1'b1;
      seen = 0;
      repeat (10) begin
         tick();
         if (res_valid) seen++;
      end
      check("post_rst_stale", seen, 0);

      send(3'd0, 16'h0010, 16'h0020);
      expect_result("post_rst_add", 16'h0030, 3'd0);
      tick();
      wait_idle();
      repeat (2) tick();

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
